cla16_adder: RTL and testbench



---
 rtl/cla16_adder_pkg.sv | 14 +
 rtl/cla16_adder_if.sv | 38 +++
 rtl/cla16_adder_cla4_block.sv | 39 +++
 rtl/cla16_adder.sv | 89 ++++++++
 tb/tb_cla16_adder.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/cla16_adder_pkg.sv
// Shared constants for the two-level carry-lookahead adder.
// Group size, default width and group count helper.
package cla_pkg;

  localparam int GROUP_W   = 4;
  localparam int WIDTH_DEF = 16;

  function automatic int num_groups(input int w);
    return w / GROUP_W;
  endfunction

  localparam int NUM_GROUPS = num_groups(WIDTH_DEF);

endpackage

// File: rtl/cla16_adder_if.sv
// Operand/result bundle of the registered CLA adder.
// Port ovf exists only when CLA_OVERFLOW_FLAG_EN is defined.
interface cla16_adder_if #(
  parameter int WIDTH = 16
);

  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic             cin;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef CLA_OVERFLOW_FLAG_EN
  logic             ovf;
`endif

  modport master (
    output in1,
    output in2,
    output cin,
    input  sum,
`ifdef CLA_OVERFLOW_FLAG_EN
    input  ovf,
`endif
    input  cout
  );

  modport slave (
    input  in1,
    input  in2,
    input  cin,
    output sum,
`ifdef CLA_OVERFLOW_FLAG_EN
    output ovf,
`endif
    output cout
  );

endinterface

// File: rtl/cla16_adder_cla4_block.sv
// 4-bit lookahead group: flattened internal carries,
// group generate/propagate for the second lookahead level.
module cla4_block (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       gg,
  output logic       gp
);

  logic [3:0] g;
  logic [3:0] p;
  logic [3:0] c;

  assign g = a & b;
  assign p = a ^ b;

  // Carries are two-level SOP, no ripple between bits
  assign c[0] = ci;
  assign c[1] = g[0]
              | (p[0] & ci);
  assign c[2] = g[1]
              | (p[1] & g[0])
              | (p[1] & p[0] & ci);
  assign c[3] = g[2]
              | (p[2] & g[1])
              | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & ci);

  assign s = p ^ c;

  assign gg = g[3]
            | (p[3] & g[2])
            | (p[3] & p[2] & g[1])
            | (p[3] & p[2] & p[1] & g[0]);
  assign gp = &p;

endmodule

// File: rtl/cla16_adder.sv
// Registered two-level carry-lookahead adder.
// Optional signed overflow output: define CLA_OVERFLOW_FLAG_EN.
module cla16_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  cla16_adder_if.slave   bus
);

  localparam int NG = num_groups(WIDTH);

  logic [NG-1:0]    gg;
  logic [NG-1:0]    gp;
  logic [NG:0]      gc;
  logic [WIDTH-1:0] s_comb;

  for (genvar j = 0; j < NG; j++) begin : g_grp
    cla4_block u_blk (
      .a  (bus.in1[j*GROUP_W +: GROUP_W]),
      .b  (bus.in2[j*GROUP_W +: GROUP_W]),
      .ci (gc[j]),
      .s  (s_comb[j*GROUP_W +: GROUP_W]),
      .gg (gg[j]),
      .gp (gp[j])
    );
  end

  // Each group carry-in is expanded directly from GG/GP/cin
  always_comb begin
    logic acc;
    logic pr;
    gc    = '0;
    gc[0] = bus.cin;
    for (int j = 0; j < NG; j++) begin
      acc = 1'b0;
      for (int k = 0; k <= j; k++) begin
        pr = gg[k];
        for (int m = k + 1; m <= j; m++) begin
          pr = pr & gp[m];
        end
        acc = acc | pr;
      end
      pr = bus.cin;
      for (int m = 0; m <= j; m++) begin
        pr = pr & gp[m];
      end
      gc[j+1] = acc | pr;
    end
  end

  logic [WIDTH-1:0] sum_q;
  logic             cout_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      sum_q  <= s_comb;
      cout_q <= gc[NG];
    end
  end

  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;

`ifdef CLA_OVERFLOW_FLAG_EN
  logic ovf_d;
  logic ovf_q;

  // Same-sign operands with a differing result sign: c[W] ^ c[W-1]
  assign ovf_d = (bus.in1[WIDTH-1] == bus.in2[WIDTH-1])
               & (s_comb[WIDTH-1] != bus.in1[WIDTH-1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign bus.ovf = ovf_q;
`endif

endmodule

// File: tb/tb_cla16_adder.sv
// Directed and random checks of the registered CLA adder.
// Expected results are hand values or in1+in2+cin at 17 bits.
module tb_cla16_adder;

  logic clk;
  logic rst_n;
  int   compared;
  int   mismatched;

  cla16_adder_if #(.WIDTH(16)) ifc ();

  cla16_adder #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [15:0] a,
                       input logic [15:0] b,
                       input logic c);
    ifc.in1 = a;
    ifc.in2 = b;
    ifc.cin = c;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [16:0] ref_v;
    logic [15:0] a;
    logic [15:0] b;
    logic        c;
    compared   = 0;
    mismatched = 0;

    // Reset with no clock edge yet
    rst_n = 1'b0;
    drive(16'h1234, 16'h1111, 1'b0);
    #2;
    chk("rst_sum", 32'(ifc.sum), 32'h0);
    chk("rst_cout", 32'(ifc.cout), 32'h0);
`ifdef CLA_OVERFLOW_FLAG_EN
    chk("rst_ovf", 32'(ifc.ovf), 32'h0);
`endif
    step();
    chk("rst_hold_sum", 32'(ifc.sum), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("rel_sum", 32'(ifc.sum), 32'h2345);
    chk("rel_cout", 32'(ifc.cout), 32'h0);

    @(negedge clk);
    drive(16'h0000, 16'h0000, 1'b0);
    step();
    chk("zero_sum", 32'(ifc.sum), 32'h0);
    chk("zero_cout", 32'(ifc.cout), 32'h0);

    @(negedge clk);
    drive(16'hAAAA, 16'h5555, 1'b0);
    step();
    chk("alt_sum", 32'(ifc.sum), 32'hFFFF);
    chk("alt_cout", 32'(ifc.cout), 32'h0);

    @(negedge clk);
    drive(16'hAAAA, 16'h5555, 1'b1);
    step();
    chk("prop_sum", 32'(ifc.sum), 32'h0000);
    chk("prop_cout", 32'(ifc.cout), 32'h1);

    @(negedge clk);
    drive(16'hFFFF, 16'hFFFF, 1'b1);
    step();
    chk("max_sum", 32'(ifc.sum), 32'hFFFF);
    chk("max_cout", 32'(ifc.cout), 32'h1);

    @(negedge clk);
    drive(16'h0FFF, 16'h0001, 1'b0);
    step();
    chk("grp_sum", 32'(ifc.sum), 32'h1000);
    chk("grp_cout", 32'(ifc.cout), 32'h0);

    @(negedge clk);
    drive(16'h7FFF, 16'h0001, 1'b0);
    step();
    chk("ovf_sum", 32'(ifc.sum), 32'h8000);
    chk("ovf_cout", 32'(ifc.cout), 32'h0);
`ifdef CLA_OVERFLOW_FLAG_EN
    chk("ovf_flag", 32'(ifc.ovf), 32'h1);
`endif

    @(negedge clk);
    drive(16'h8000, 16'h8000, 1'b0);
    step();
    chk("neg_sum", 32'(ifc.sum), 32'h0000);
    chk("neg_cout", 32'(ifc.cout), 32'h1);
`ifdef CLA_OVERFLOW_FLAG_EN
    chk("neg_ovf", 32'(ifc.ovf), 32'h1);
`endif

    // Random vectors, every third one limited to 15 bits
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      a = 16'($urandom);
      b = 16'($urandom);
      c = 1'($urandom);
      if (i % 3 == 0) begin
        a[15] = 1'b0;
        b[15] = 1'b0;
      end
      drive(a, b, c);
      ref_v = {1'b0, a} + {1'b0, b} + {16'h0, c};
      step();
      chk("rnd_sum", 32'(ifc.sum), 32'(ref_v[15:0]));
      chk("rnd_cout", 32'(ifc.cout), 32'(ref_v[16]));
`ifdef CLA_OVERFLOW_FLAG_EN
      chk("rnd_ovf", 32'(ifc.ovf),
          32'((a[15] == b[15]) && (ref_v[15] != a[15])));
`endif
    end

    // Mid-stream asynchronous reset
    @(negedge clk);
    drive(16'h1357, 16'h2468, 1'b1);
    step();
    chk("pre_rst_sum", 32'(ifc.sum), 32'h37C0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_sum", 32'(ifc.sum), 32'h0);
    chk("mid_rst_cout", 32'(ifc.cout), 32'h0);
    @(negedge clk);
    drive(16'hFFFF, 16'h0001, 1'b0);
    step();
    chk("rst_hold1_sum", 32'(ifc.sum), 32'h0);
    chk("rst_hold1_cout", 32'(ifc.cout), 32'h0);
    @(negedge clk);
    drive(16'h0100, 16'h0200, 1'b0);
    rst_n = 1'b1;
    #1;
    chk("rel_pre_edge", 32'(ifc.sum), 32'h0);
    step();
    chk("rel2_sum", 32'(ifc.sum), 32'h0300);
    chk("rel2_cout", 32'(ifc.cout), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

endmodule
